cache_ctrl: RTL and testbench

- Direct-mapped, write-through, write-no-allocate cache controller that sits directly upstream of backing_store.
- Accepts single-word core requests.
- Serves read hits from an internal tag/data array.
- Forwards read misses and all writes to backing_store over its req_do/req_done handshake.
- One word per line; one outstanding request.

---
 rtl/cache_ctrl.sv | 170 +++++++++++++++++
 tb/tb_cache_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl.sv
// rtl/cache_ctrl.sv - direct-mapped write-through, write-no-allocate cache controller.
// Optional hit/miss counters are built when CACHE_STATS_EN is defined.
module cache_ctrl #(
  parameter int LINES  = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [31:0]       core_wdata,
  output logic [31:0]       core_rdata,
  output logic              core_done,
  output logic              core_busy,
  output logic [ADDR_W-1:0] req_addr,
  output logic [31:0]       req_data,
  output logic              req_type,
  output logic              req_do,
  input  logic [31:0]       O_data,
  input  logic              req_done
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses
`endif
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_WR_ISSUE,
    S_WR_WAIT,
    S_RESP
  } state_t;

  state_t            r_state;
  logic [ADDR_W-3:0] r_waddr;
  logic [31:0]       r_wdata;
  logic [LINES-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag_mem  [LINES];
  logic [31:0]       r_data_mem [LINES];

  logic [IDX_W-1:0]  w_in_idx;
  logic [TAG_W-1:0]  w_in_tag;
  logic              w_in_hit;
  logic [IDX_W-1:0]  w_lat_idx;
  logic [TAG_W-1:0]  w_lat_tag;
  logic              w_lat_hit;
  logic              w_fill;
  logic              w_wr_upd;
  logic              w_unused_bits;

  assign w_in_idx      = core_addr[IDX_W+1:2];
  assign w_in_tag      = core_addr[ADDR_W-1:IDX_W+2];
  assign w_in_hit      = r_valid[w_in_idx] && (r_tag_mem[w_in_idx] == w_in_tag);
  assign w_lat_idx     = r_waddr[IDX_W-1:0];
  assign w_lat_tag     = r_waddr[ADDR_W-3:IDX_W];
  assign w_lat_hit     = r_valid[w_lat_idx] && (r_tag_mem[w_lat_idx] == w_lat_tag);
  assign w_fill        = (r_state == S_RD_WAIT) && req_done;
  assign w_wr_upd      = (r_state == S_WR_WAIT) && req_done && w_lat_hit;
  assign w_unused_bits = ^core_addr[1:0];

  // Tag/data storage carries no reset; validity lives in r_valid.
  always_ff @(posedge clk) begin
    if (reset && w_fill) begin
      r_tag_mem[w_lat_idx]  <= w_lat_tag;
      r_data_mem[w_lat_idx] <= O_data;
    end else if (reset && w_wr_upd) begin
      r_data_mem[w_lat_idx] <= r_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_valid    <= '0;
      core_rdata <= '0;
      core_done  <= 1'b0;
      core_busy  <= 1'b0;
      req_addr   <= '0;
      req_data   <= '0;
      req_type   <= 1'b0;
      req_do     <= 1'b0;
    end else begin
      core_done <= 1'b0;
      req_do    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (core_req) begin
            r_waddr   <= core_addr[ADDR_W-1:2];
            r_wdata   <= core_wdata;
            core_busy <= 1'b1;
            if (core_we) begin
              r_state <= S_WR_ISSUE;
            end else if (w_in_hit) begin
              core_rdata <= r_data_mem[w_in_idx];
              core_done  <= 1'b1;
              r_state    <= S_RESP;
            end else begin
              r_state <= S_RD_ISSUE;
            end
          end
        end
        S_RD_ISSUE: begin
          req_do   <= 1'b1;
          req_type <= 1'b0;
          req_addr <= {r_waddr, 2'b00};
          r_state  <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (req_done) begin
            r_valid[w_lat_idx] <= 1'b1;
            core_rdata         <= O_data;
            core_done          <= 1'b1;
            r_state            <= S_RESP;
          end
        end
        S_WR_ISSUE: begin
          req_do   <= 1'b1;
          req_type <= 1'b1;
          req_addr <= {r_waddr, 2'b00};
          req_data <= r_wdata;
          r_state  <= S_WR_WAIT;
        end
        S_WR_WAIT: begin
          // Write misses do not allocate; the data array update is gated on w_lat_hit.
          if (req_done) begin
            core_done <= 1'b1;
            r_state   <= S_RESP;
          end
        end
        S_RESP: begin
          core_busy <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          core_busy <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  logic w_rd_capture;
  assign w_rd_capture = (r_state == S_IDLE) && core_req && !core_we;

  // Counters saturate rather than wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (w_rd_capture) begin
      if (w_in_hit) begin
        if (stat_hits != 32'hFFFF_FFFF) stat_hits <= stat_hits + 32'd1;
      end else begin
        if (stat_misses != 32'hFFFF_FFFF) stat_misses <= stat_misses + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// tb/tb_cache_ctrl.sv - scoreboard bench for cache_ctrl with a 1-cycle backing store model.
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        core_req, core_we;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        core_done, core_busy;
  logic [31:0] req_addr, req_data;
  logic        req_type, req_do;
  logic [31:0] O_data;
  logic        req_done;
`ifdef CACHE_STATS_EN
  logic [31:0] stat_hits, stat_misses;
`endif

  cache_ctrl #(.LINES(16), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_done(core_done), .core_busy(core_busy),
    .req_addr(req_addr), .req_data(req_data), .req_type(req_type), .req_do(req_do),
    .O_data(O_data), .req_done(req_done)
`ifdef CACHE_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    int          lat;
    int          t0;
  } core_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        typ;
    logic [31:0] data;
  } req_exp_t;

  core_exp_t   core_q[$];
  req_exp_t    req_q[$];
  logic [31:0] mem [logic [31:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Core-side monitor
  always @(negedge clk) begin : core_mon
    core_exp_t e;
    if (reset && core_done) begin
      if (core_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_core_done: got core_done=1 expected 0 (cycle %0d)", cyc);
      end else begin
        e = core_q.pop_front();
        chk("core_rdata", core_rdata, e.rdata);
        chk("core_latency", cyc - e.t0, e.lat);
      end
    end
  end

  // Backing store: checks each req_do against the expected queue, answers one cycle later.
  initial begin : store
    req_exp_t    r;
    logic [31:0] a;
    logic        t;
    req_done = 1'b0;
    O_data   = '0;
    forever begin
      @(negedge clk);
      if (req_do === 1'b1) begin
        a = req_addr;
        t = req_type;
        if (req_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req_do: got req_do=1 addr %h expected none", a);
        end else begin
          r = req_q.pop_front();
          chk("req_addr", a, r.addr);
          chk("req_type", {31'd0, t}, {31'd0, r.typ});
          if (r.typ) chk("req_data", req_data, r.data);
        end
        if (t) mem[a] = req_data;
        @(posedge clk);
        #1;
        chk("req_do_pulse", {31'd0, req_do}, 32'd0);
        O_data   = mem.exists(a) ? mem[a] : 32'd0;
        req_done = 1'b1;
        @(posedge clk);
        #1;
        req_done = 1'b0;
      end
    end
  end

  task automatic start_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, input int lat, input bit exp_done);
    core_exp_t e;
    req_exp_t  r;
    core_we    = we;
    core_addr  = addr;
    core_wdata = wdata;
    core_req   = 1'b1;
    if (exp_done) begin
      e.rdata = exp_rdata;
      e.lat   = lat;
      e.t0    = cyc;
      core_q.push_back(e);
    end
    if (lat != 1) begin
      r.addr = addr;
      r.typ  = we;
      r.data = wdata;
      req_q.push_back(r);
    end
    @(posedge clk);
    #1;
    core_req = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (!core_busy) return;
    end
    checks++;
    errors++;
    $display("FAIL idle_timeout: got core_busy=1 expected 0 within 30 cycles");
  endtask

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input int lat);
    start_req(we, addr, wdata, exp_rdata, lat, 1'b1);
    wait_idle();
  endtask

  initial begin
    #50000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin : main
    bit seen;
    core_req   = 1'b0;
    core_we    = 1'b0;
    core_addr  = '0;
    core_wdata = '0;
    mem[32'h0000_03FC] = 32'hAABB_CCDD;
    mem[32'h0000_0000] = 32'h0000_1111;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_core_rdata", core_rdata, 32'd0);
    chk("rst_core_done", {31'd0, core_done}, 32'd0);
    chk("rst_core_busy", {31'd0, core_busy}, 32'd0);
    chk("rst_req_do", {31'd0, req_do}, 32'd0);
    chk("rst_req_type", {31'd0, req_type}, 32'd0);
    chk("rst_req_addr", req_addr, 32'd0);
    chk("rst_req_data", req_data, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    do_req(1'b0, 32'h0000_03FC, 32'd0,        32'hAABB_CCDD, 4);
    do_req(1'b0, 32'h0000_03FC, 32'd0,        32'hAABB_CCDD, 1);
    do_req(1'b1, 32'h0000_0200, 32'h1234_5678, 32'hAABB_CCDD, 4);
    do_req(1'b0, 32'h0000_0200, 32'd0,        32'h1234_5678, 4);
    do_req(1'b0, 32'h0000_0200, 32'd0,        32'h1234_5678, 1);
    do_req(1'b0, 32'h0000_0000, 32'd0,        32'h0000_1111, 4);
    do_req(1'b0, 32'h0000_0200, 32'd0,        32'h1234_5678, 4);
    do_req(1'b1, 32'h0000_03FC, 32'h0102_0304, 32'h1234_5678, 4);
    do_req(1'b0, 32'h0000_03FC, 32'd0,        32'h0102_0304, 1);

    // Second request while busy must be dropped.
    start_req(1'b0, 32'h0000_0000, 32'd0, 32'h0000_1111, 4, 1'b1);
    core_we    = 1'b1;
    core_addr  = 32'h0000_0040;
    core_wdata = 32'hDEAD_BEEF;
    core_req   = 1'b1;
    @(posedge clk);
    #1;
    core_req = 1'b0;
    wait_idle();

    // Abort a read in RD_WAIT; the store still answers afterwards.
    start_req(1'b0, 32'h0000_0100, 32'd0, 32'd0, 4, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (req_do) seen = 1'b1;
    end
    chk("abort_req_do_seen", {31'd0, seen}, 32'd1);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    chk("abort_core_rdata", core_rdata, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("abort_core_busy", {31'd0, core_busy}, 32'd0);

    do_req(1'b0, 32'h0000_03FC, 32'd0,        32'h0102_0304, 4);
    do_req(1'b0, 32'h0000_03FC, 32'd0,        32'h0102_0304, 1);
    do_req(1'b0, 32'h0000_03FC, 32'd0,        32'h0102_0304, 1);
    do_req(1'b1, 32'h0000_03FC, 32'h0BAD_F00D, 32'h0102_0304, 4);
    do_req(1'b0, 32'h0000_03FC, 32'd0,        32'h0BAD_F00D, 1);
`ifdef CACHE_STATS_EN
    chk("stat_misses", stat_misses, 32'd1);
    chk("stat_hits", stat_hits, 32'd3);
`endif

    repeat (5) @(posedge clk);
    #1;
    chk("core_q_empty", core_q.size(), 32'd0);
    chk("req_q_empty", req_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
